prog_loader: RTL and testbench

Program loader for the instruction memory: receives a byte stream from the UART receiver and assembles it into 32-bit little-endian words. Writes each word into the instruction RAM through a single write port. Holds the core in reset until the whole image has been written. It is the write-side counterpart of the instruction memory read port and sits between `uart_rx` and the instruction RAM in the board top level.

---
 rtl/prog_loader.sv | 147 ++++++++++++++
 tb/tb_prog_loader.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/prog_loader.sv
// rtl/prog_loader.sv - UART byte stream to instruction RAM loader; holds the core in reset until the image is in.
// Optional trailing XOR checksum byte enabled by defining LOADER_CHECKSUM_EN.
module prog_loader #(
    parameter int unsigned MEM_WORDS = 1024
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        rx_valid_i,
    input  logic [7:0]  rx_data_i,
    output logic        we_o,
    output logic [31:0] waddr_o,
    output logic [31:0] wdata_o,
    output logic        core_rst_o,
    output logic        done_o,
    output logic        err_o
);

    typedef enum logic [2:0] {
        S_LEN,
        S_DATA,
`ifdef LOADER_CHECKSUM_EN
        S_CHK,
        S_HALT,
`endif
        S_DONE
    } state_t;

    state_t      state_q;
    logic [1:0]  byte_cnt_q;
    logic [23:0] asm_q;
    logic [31:0] len_q;
    logic [31:0] idx_q;
    logic        we_q;
    logic [31:0] waddr_q;
    logic [31:0] wdata_q;
    logic        core_rst_q;
    logic        done_q;
    logic        err_q;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum_q;
`endif

    // The 4th byte is taken straight from the input, so only three bytes are buffered.
    logic [31:0] word_w;
    logic        last_byte_w;
    assign word_w      = {rx_data_i, asm_q};
    assign last_byte_w = (byte_cnt_q == 2'd3);

    assign we_o       = we_q;
    assign waddr_o    = waddr_q;
    assign wdata_o    = wdata_q;
    assign core_rst_o = core_rst_q;
    assign done_o     = done_q;
    assign err_o      = err_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_LEN;
            byte_cnt_q <= 2'd0;
            asm_q      <= 24'd0;
            len_q      <= 32'd0;
            idx_q      <= 32'd0;
            we_q       <= 1'b0;
            waddr_q    <= 32'd0;
            wdata_q    <= 32'd0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum_q     <= 8'd0;
`endif
        end else begin
            we_q <= 1'b0;
            case (state_q)
                S_LEN, S_DATA: begin
                    if (rx_valid_i) begin
`ifdef LOADER_CHECKSUM_EN
                        csum_q <= csum_q ^ rx_data_i;
`endif
                        byte_cnt_q <= byte_cnt_q + 2'd1;
                        if (!last_byte_w) begin
                            asm_q[{byte_cnt_q, 3'b000} +: 8] <= rx_data_i;
                        end else if (state_q == S_LEN) begin
                            len_q <= word_w;
                            idx_q <= 32'd0;
                            if (word_w == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
                                state_q <= S_CHK;
`else
                                state_q    <= S_DONE;
                                done_q     <= 1'b1;
                                core_rst_q <= 1'b0;
`endif
                            end else begin
                                state_q <= S_DATA;
                            end
                        end else begin
                            if (idx_q < 32'(MEM_WORDS)) begin
                                we_q    <= 1'b1;
                                waddr_q <= idx_q << 2;
                                wdata_q <= word_w;
                            end else begin
                                err_q <= 1'b1;
                            end
                            idx_q <= idx_q + 32'd1;
                            // done_o follows one cycle later from S_DONE, after the final write pulse.
                            if (idx_q == len_q - 32'd1) begin
`ifdef LOADER_CHECKSUM_EN
                                state_q <= S_CHK;
`else
                                state_q <= S_DONE;
`endif
                            end
                        end
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                S_CHK: begin
                    byte_cnt_q <= 2'd0;
                    if (rx_valid_i) begin
                        if (rx_data_i == csum_q) begin
                            state_q    <= S_DONE;
                            done_q     <= 1'b1;
                            core_rst_q <= 1'b0;
                        end else begin
                            state_q <= S_HALT;
                            err_q   <= 1'b1;
                        end
                    end
                end
                S_HALT: begin
                    byte_cnt_q <= 2'd0;
                end
`endif
                S_DONE: begin
                    byte_cnt_q <= 2'd0;
                    done_q     <= 1'b1;
                    core_rst_q <= 1'b0;
                end
                default: begin
                    state_q <= S_LEN;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prog_loader.sv
// tb/tb_prog_loader.sv - scoreboard bench for prog_loader with MEM_WORDS=4.
module tb_prog_loader;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_valid = 1'b0;
    logic [7:0]  rx_data = 8'd0;
    logic        we;
    logic [31:0] waddr;
    logic [31:0] wdata;
    logic        core_rst;
    logic        done;
    logic        err;

    int checks = 0;
    int failures = 0;
    int pushed = 0;
    int seen = 0;
    logic [63:0] sb[$];
    logic [7:0]  img[$];

    always #5 clk = ~clk;

    prog_loader #(.MEM_WORDS(4)) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .rx_valid_i (rx_valid),
        .rx_data_i  (rx_data),
        .we_o       (we),
        .waddr_o    (waddr),
        .wdata_o    (wdata),
        .core_rst_o (core_rst),
        .done_o     (done),
        .err_o      (err)
    );

    // Monitor: every write pulse must match the head of the scoreboard.
    always @(negedge clk) begin
        if (we) begin
            logic [63:0] exp;
            seen++;
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL unexpected_write got addr=%h data=%h required=none", waddr, wdata);
            end else begin
                exp = sb.pop_front();
                if ({waddr, wdata} !== exp) begin
                    failures++;
                    $display("FAIL write got addr=%h data=%h required addr=%h data=%h",
                             waddr, wdata, exp[63:32], exp[31:0]);
                end
            end
        end
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h required=%h", name, got, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_we"}, 32'(we), 32'd0);
        check({tag, "_waddr"}, waddr, 32'd0);
        check({tag, "_wdata"}, wdata, 32'd0);
        check({tag, "_core_rst"}, 32'(core_rst), 32'd1);
        check({tag, "_done"}, 32'(done), 32'd0);
        check({tag, "_err"}, 32'(err), 32'd0);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst = 1'b1;
        rx_valid = 1'b0;
        #1;
        check_reset_outputs({tag, "_in_rst"});
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs({tag, "_after_rst"});
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_valid = 1'b1;
        rx_data = b;
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic send_img(input int maxgap);
        foreach (img[i]) begin
            repeat ($urandom_range(0, maxgap)) @(negedge clk);
            send_byte(img[i]);
        end
    endtask

    function automatic logic [7:0] img_csum();
        logic [7:0] c = 8'd0;
        foreach (img[i]) c = c ^ img[i];
        return c;
    endfunction

    task automatic push_word(input logic [31:0] addr, input logic [31:0] data);
        sb.push_back({addr, data});
        pushed++;
    endtask

    // Called on the negedge right after the edge that took the last frame byte.
    task automatic finish_frame(input string tag, input bit delayed);
`ifdef LOADER_CHECKSUM_EN
        check({tag, "_done_before_chk"}, 32'(done), 32'd0);
        send_byte(img_csum());
`else
        if (delayed) begin
            check({tag, "_done_early"}, 32'(done), 32'd0);
            check({tag, "_core_rst_early"}, 32'(core_rst), 32'd1);
            @(negedge clk);
        end
`endif
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_core_rst"}, 32'(core_rst), 32'd0);
    endtask

    task automatic set_simple_img();
        img = '{8'h02, 8'h00, 8'h00, 8'h00,
                8'h13, 8'h05, 8'h10, 8'h00,
                8'h93, 8'h05, 8'h20, 8'h00};
    endtask

    initial begin
        logic [31:0] w;

        do_reset("reset");

        // Simple load, back-to-back bytes, then bytes after DONE.
        set_simple_img();
        push_word(32'h0, 32'h00100513);
        push_word(32'h4, 32'h00200593);
        send_img(0);
        finish_frame("simple", 1'b1);
        check("simple_err", 32'(err), 32'd0);
        repeat (4) send_byte(8'hFF);
        repeat (3) @(negedge clk);
        check("post_done_done", 32'(done), 32'd1);
        check("post_done_waddr", waddr, 32'h4);
        check("post_done_wdata", wdata, 32'h00200593);

        // Same image with random gaps.
        do_reset("gapped");
        set_simple_img();
        push_word(32'h0, 32'h00100513);
        push_word(32'h4, 32'h00200593);
        send_img(20);
        finish_frame("gapped", 1'b1);

        // Zero length.
        do_reset("zero");
        img = '{8'h00, 8'h00, 8'h00, 8'h00};
        send_img(0);
        finish_frame("zero", 1'b0);
        check("zero_err", 32'(err), 32'd0);
        check("zero_waddr", waddr, 32'h0);

        // Overflow: L=6 into a 4-word memory.
        do_reset("ovf");
        img = '{8'h06, 8'h00, 8'h00, 8'h00};
        for (int k = 0; k < 6; k++) begin
            w = 32'hA0B0C000 + 32'(k);
            for (int b = 0; b < 4; b++) img.push_back(8'(w >> (8 * b)));
            if (k < 4) push_word(32'(4 * k), w);
        end
        send_img(1);
        finish_frame("ovf", 1'b1);
        check("ovf_err", 32'(err), 32'd1);
        check("ovf_last_waddr", waddr, 32'hC);

        // Mid-frame reset after one full word and two bytes of the next.
        do_reset("mid_pre");
        img = '{8'h03, 8'h00, 8'h00, 8'h00, 8'h78, 8'h56, 8'h34, 8'h12, 8'hAA, 8'hBB};
        push_word(32'h0, 32'h12345678);
        send_img(0);
        do_reset("mid");
        img = '{8'h01, 8'h00, 8'h00, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        push_word(32'h0, 32'hDEADBEEF);
        send_img(3);
        finish_frame("mid", 1'b1);

`ifdef LOADER_CHECKSUM_EN
        // Wrong checksum keeps the core in reset.
        do_reset("badchk");
        set_simple_img();
        push_word(32'h0, 32'h00100513);
        push_word(32'h4, 32'h00200593);
        send_img(0);
        send_byte(img_csum() ^ 8'h01);
        repeat (2) @(negedge clk);
        check("badchk_err", 32'(err), 32'd1);
        check("badchk_done", 32'(done), 32'd0);
        check("badchk_core_rst", 32'(core_rst), 32'd1);
`endif

        repeat (5) @(negedge clk);
        check("sb_empty", 32'(sb.size()), 32'd0);
        check("write_count", 32'(seen), 32'(pushed));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
